// File: rtl/interrupt_return_handler_pkg.sv
// Shared definitions for the RTI return sequencer: FSM states, micro-op encodings
// and the CCR width restored at the end of the sequence.
package interrupt_return_handler_pkg;

  localparam int CCR_W = 3;

  localparam logic [15:0] BUBBLE_INSTR_DEF    = 16'h07F8;
  localparam logic [15:0] POP_FLAGS_INSTR_DEF = 16'hF540;
  localparam logic [15:0] POP_LO_INSTR_DEF    = 16'hF520;
  localparam logic [15:0] POP_HI_INSTR_DEF    = 16'hF500;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    POP_F,
    POP_L,
    POP_H,
    WAIT_DATA,
    RESTORE
  } state_t;

endpackage

// File: rtl/interrupt_return_handler_collector.sv
// Collects the three popped words (flags, PC lo, PC hi) from the memory stage and
// exposes next-cycle capture values so the sequencer can restore on the capture edge.
module rti_pop_collector
  import interrupt_return_handler_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             pop_fire,
  input  logic             mem_valid,
  input  logic [15:0]      mem_data,
  output logic             all_captured,
  output logic [CCR_W-1:0] flags_next,
  output logic [31:0]      pc_next
);

  logic [1:0]       issued;
  logic [1:0]       cap_cnt;
  logic [1:0]       issued_eff;
  logic             accept;
  logic [CCR_W-1:0] cap_flags;
  logic [15:0]      cap_lo;
  logic [15:0]      cap_hi;
  logic [15:0]      lo_next;
  logic [15:0]      hi_next;

  // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
  always_comb begin
    // A POP in flight this cycle already counts as issued, so same-cycle returns are taken.
    issued_eff   = issued + {1'b0, pop_fire};
    accept       = mem_valid && (cap_cnt < issued_eff);
    flags_next   = cap_flags;
    lo_next      = cap_lo;
    hi_next      = cap_hi;
    if (accept) begin
      case (cap_cnt)
        2'd0:    flags_next = mem_data[CCR_W-1:0];
        2'd1:    lo_next    = mem_data;
        default: hi_next    = mem_data;
      endcase
    end
    all_captured = (cap_cnt == 2'd3) || (accept && cap_cnt == 2'd2);
    pc_next      = {hi_next, lo_next};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued  <= '0;
      cap_cnt <= '0;
    end else if (clear) begin
      issued  <= '0;
      cap_cnt <= '0;
    end else begin
      if (pop_fire) issued  <= issued + 2'd1;
      if (accept)   cap_cnt <= cap_cnt + 2'd1;
    end
  end

  // NOTE: the capture registers are few and feed outputs, so they are reset like any flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_flags <= '0;
      cap_lo    <= '0;
      cap_hi    <= '0;
    end else begin
      cap_flags <= flags_next;
      cap_lo    <= lo_next;
      cap_hi    <= hi_next;
    end
  end

endmodule

// File: rtl/interrupt_return_handler.sv
// RTI sequencer: drains the pipeline, injects three POP micro-ops, waits for the popped
// words, then redirects fetch to the saved PC and restores CCR, or aborts on timeout.
module interrupt_return_handler
  import interrupt_return_handler_pkg::*;
#(
  parameter int          DRAIN_CYCLES    = 2,
  parameter int          TIMEOUT_CYCLES  = 32,
  parameter logic [15:0] BUBBLE_INSTR    = BUBBLE_INSTR_DEF,
  parameter logic [15:0] POP_FLAGS_INSTR = POP_FLAGS_INSTR_DEF,
  parameter logic [15:0] POP_LO_INSTR    = POP_LO_INSTR_DEF,
  parameter logic [15:0] POP_HI_INSTR    = POP_HI_INSTR_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rtiDecoded,
  input  logic             memDataValid,
  input  logic [15:0]      memData,
  output logic             injectValid,
  output logic [15:0]      injectInstruction,
  output logic             stallFetch,
  output logic             restoreValid,
  output logic [31:0]      restorePc,
  output logic [CCR_W-1:0] restoreFlags,
  output logic             busy,
  output logic             abortPulse
);

  state_t           state, state_next;
  logic [2:0]       drain_cnt, drain_cnt_next;
  logic [15:0]      wait_cnt, wait_cnt_next;
  logic             start, abort, pop_fire, all_captured;
  logic [CCR_W-1:0] flags_next;
  logic [31:0]      pc_next;
  logic             inject_n;
  logic [15:0]      instr_n;

  rti_pop_collector u_collector (
    .clk          (clk),
    .rst          (rst),
    .clear        (start || abort),
    .pop_fire     (pop_fire),
    .mem_valid    (memDataValid),
    .mem_data     (memData),
    .all_captured (all_captured),
    .flags_next   (flags_next),
    .pc_next      (pc_next)
  );

  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    wait_cnt_next  = wait_cnt;
    start          = 1'b0;
    abort          = 1'b0;
    pop_fire       = (state == POP_F) || (state == POP_L) || (state == POP_H);
    case (state)
      IDLE: if (rtiDecoded) begin
        state_next     = DRAIN;
        drain_cnt_next = '0;
        start          = 1'b1;
      end
      DRAIN: begin
        if (drain_cnt == 3'(DRAIN_CYCLES - 1)) state_next = POP_F;
        else drain_cnt_next = drain_cnt + 3'd1;
      end
      POP_F: state_next = POP_L;
      POP_L: state_next = POP_H;
      POP_H: begin
        state_next    = WAIT_DATA;
        wait_cnt_next = '0;
      end
      WAIT_DATA: begin
        // A third word landing on the last timeout cycle still completes the return.
        if (all_captured) begin
          state_next = RESTORE;
        end else if (wait_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
          state_next = IDLE;
          abort      = 1'b1;
        end else if (wait_cnt != 16'hFFFF) begin
          wait_cnt_next = wait_cnt + 16'd1;
        end
      end
      RESTORE: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    inject_n = (state_next == DRAIN) || (state_next == POP_F) || (state_next == POP_L) ||
               (state_next == POP_H) || (state_next == WAIT_DATA);
    case (state_next)
      POP_F:   instr_n = POP_FLAGS_INSTR;
      POP_L:   instr_n = POP_LO_INSTR;
      POP_H:   instr_n = POP_HI_INSTR;
      default: instr_n = BUBBLE_INSTR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
      wait_cnt  <= wait_cnt_next;
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      injectValid       <= 1'b0;
      injectInstruction <= BUBBLE_INSTR;
      stallFetch        <= 1'b0;
      restoreValid      <= 1'b0;
      restorePc         <= '0;
      restoreFlags      <= '0;
      busy              <= 1'b0;
      abortPulse        <= 1'b0;
    end else begin
      injectValid       <= inject_n;
      injectInstruction <= instr_n;
      stallFetch        <= inject_n;
      restoreValid      <= (state_next == RESTORE);
      busy              <= (state_next != IDLE);
      abortPulse        <= abort;
      if (state_next == RESTORE) begin
        restorePc    <= pc_next;
        restoreFlags <= flags_next;
      end
    end
  end

endmodule

// File: tb/tb_interrupt_return_handler.sv
// Self-checking bench for interrupt_return_handler: directed and randomized RTI sequences
// checked cycle by cycle against a timeline model derived from the sequence rules.
module tb_interrupt_return_handler;

  localparam int          D   = 2;
  localparam int          TMO = 32;
  localparam logic [15:0] BUB = 16'h07F8;
  localparam logic [15:0] PF  = 16'hF540;
  localparam logic [15:0] PL  = 16'hF520;
  localparam logic [15:0] PH  = 16'hF500;

  logic        clk = 1'b0;
  logic        rst;
  logic        rtiDecoded, memDataValid;
  logic [15:0] memData;
  logic        injectValid, stallFetch, restoreValid, busy, abortPulse;
  logic [15:0] injectInstruction;
  logic [31:0] restorePc;
  logic [2:0]  restoreFlags;

  int          checks   = 0;
  int          failures = 0;
  int          ev_n;
  int          ev_cyc[8];
  logic [15:0] ev_dat[8];
  logic [31:0] exp_pc;
  logic [2:0]  exp_fl;

  always #5 clk = ~clk;

  interrupt_return_handler #(.DRAIN_CYCLES(D), .TIMEOUT_CYCLES(TMO)) dut (
    .clk               (clk),
    .rst               (rst),
    .rtiDecoded        (rtiDecoded),
    .memDataValid      (memDataValid),
    .memData           (memData),
    .injectValid       (injectValid),
    .injectInstruction (injectInstruction),
    .stallFetch        (stallFetch),
    .restoreValid      (restoreValid),
    .restorePc         (restorePc),
    .restoreFlags      (restoreFlags),
    .busy              (busy),
    .abortPulse        (abortPulse)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive inputs for sequence cycle n; idle data lines carry junk to prove it is ignored.
  task automatic drive(input int n, input bit hold);
    rtiDecoded   = (n == 0) ? 1'b1 : hold;
    memDataValid = 1'b0;
    memData      = 16'($urandom);
    for (int i = 0; i < ev_n; i++)
      if (ev_cyc[i] == n) begin
        memDataValid = 1'b1;
        memData      = ev_dat[i];
      end
  endtask

  task automatic set_seq(input int d0, input int d1, input int d2,
                         input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                         input bit spur);
    int base;
    base = spur ? 2 : 0;
    ev_n = base + 3;
    if (spur) begin
      ev_cyc[0] = 0; ev_dat[0] = 16'hDEAD;
      ev_cyc[1] = 1; ev_dat[1] = 16'hBEEF;
    end
    ev_cyc[base]   = D + 1 + d0;
    ev_cyc[base+1] = (D + 2 + d1 > ev_cyc[base])   ? D + 2 + d1 : ev_cyc[base] + 1;
    ev_cyc[base+2] = (D + 3 + d2 > ev_cyc[base+1]) ? D + 3 + d2 : ev_cyc[base+1] + 1;
    ev_dat[base] = a; ev_dat[base+1] = b; ev_dat[base+2] = c;
  endtask

  // Cycle 0 is the IDLE cycle with rtiDecoded high; POPs occupy cycles D+1..D+3.
  task automatic run_seq(input bit chained, input bit hold);
    int          cnt, c3, iss, r, e, wait_end;
    bit          ab, ei;
    logic [15:0] w[3];
    logic [15:0] ex_instr;
    cnt = 0; c3 = -1;
    w[0] = 16'h0; w[1] = 16'h0; w[2] = 16'h0;
    for (int i = 0; i < ev_n; i++) begin
      iss = 0;
      if (ev_cyc[i] >= D + 1) iss++;
      if (ev_cyc[i] >= D + 2) iss++;
      if (ev_cyc[i] >= D + 3) iss++;
      if (cnt < 3 && cnt < iss && ev_cyc[i] <= D + 3 + TMO) begin
        w[cnt] = ev_dat[i];
        if (cnt == 2) c3 = ev_cyc[i];
        cnt++;
      end
    end
    ab       = (c3 < 0);
    r        = ab ? D + 4 + TMO : ((c3 + 1 > D + 5) ? c3 + 1 : D + 5);
    e        = ab ? r : r + 1;
    wait_end = ab ? D + 3 + TMO : r - 1;

    if (!chained) begin
      @(negedge clk);
      check("idle_before", 32'(busy), 32'd0);
    end
    drive(0, hold);
    for (int n = 1; n <= e; n++) begin
      @(negedge clk);
      ei       = (n <= wait_end);
      ex_instr = (n == D + 1) ? PF : (n == D + 2) ? PL : (n == D + 3) ? PH : BUB;
      if (!ab && n == r) begin
        exp_pc = {w[2], w[1]};
        exp_fl = w[0][2:0];
      end
      check("busy",         32'(busy),         32'(n < e));
      check("injectValid",  32'(injectValid),  32'(ei));
      check("stallFetch",   32'(stallFetch),   32'(ei));
      check("restoreValid", 32'(restoreValid), 32'(!ab && n == r));
      check("abortPulse",   32'(abortPulse),   32'(ab && n == e));
      if (ei) check("injectInstruction", 32'(injectInstruction), 32'(ex_instr));
      if (n >= r) begin
        check("restorePc",    restorePc,          exp_pc);
        check("restoreFlags", 32'(restoreFlags),  32'(exp_fl));
      end
      drive(n, hold);
    end
  endtask

  initial begin
    rst = 1'b1; rtiDecoded = 1'b0; memDataValid = 1'b0; memData = 16'h0;
    exp_pc = 32'h0; exp_fl = 3'h0;
    #1;
    check("rst_busy",   32'(busy),              32'd0);
    check("rst_inject", 32'(injectValid),       32'd0);
    check("rst_instr",  32'(injectInstruction), 32'(BUB));
    check("rst_stall",  32'(stallFetch),        32'd0);
    check("rst_rv",     32'(restoreValid),      32'd0);
    check("rst_abort",  32'(abortPulse),        32'd0);
    check("rst_pc",     restorePc,              32'h0);
    check("rst_flags",  32'(restoreFlags),      32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Basic return, data alongside each POP: restoreValid at cycle 7.
    set_seq(0, 0, 0, 16'h0005, 16'h1234, 16'h0000, 1'b0);
    run_seq(1'b0, 1'b0);
    check("basic_pc",    restorePc,         32'h0000_1234);
    check("basic_flags", 32'(restoreFlags), 32'd5);

    // Late data: 4, 5 and 9 cycles after the POPs.
    set_seq(4, 5, 9, 16'h0002, 16'hBEEF, 16'hCAFE, 1'b0);
    run_seq(1'b0, 1'b0);
    check("late_pc", restorePc, 32'hCAFE_BEEF);

    // Spurious valids in IDLE and DRAIN.
    set_seq(0, 1, 2, 16'h0003, 16'h5A5A, 16'h00A5, 1'b1);
    run_seq(1'b0, 1'b0);
    check("spur_pc", restorePc, 32'h00A5_5A5A);

    // Timeout with only two words; PC must stay from the previous return.
    ev_n = 2;
    ev_cyc[0] = D + 1; ev_dat[0] = 16'h0007;
    ev_cyc[1] = D + 3; ev_dat[1] = 16'h1111;
    run_seq(1'b0, 1'b0);
    check("abort_pc_kept", restorePc, 32'h00A5_5A5A);

    // Third word on the final WAIT_DATA cycle still restores.
    ev_n = 3;
    ev_cyc[0] = D + 1;       ev_dat[0] = 16'h0001;
    ev_cyc[1] = D + 2;       ev_dat[1] = 16'h4321;
    ev_cyc[2] = D + 3 + TMO; ev_dat[2] = 16'h8765;
    run_seq(1'b0, 1'b0);
    check("edge_pc", restorePc, 32'h8765_4321);

    // Back-to-back: rtiDecoded held high runs exactly two sequences, then idles once dropped.
    set_seq(1, 0, 3, 16'h0006, 16'h2222, 16'h3333, 1'b0);
    run_seq(1'b0, 1'b1);
    set_seq(0, 2, 0, 16'h0004, 16'h4444, 16'h5555, 1'b0);
    run_seq(1'b1, 1'b0);
    @(negedge clk);
    check("b2b_idle0", 32'(busy), 32'd0);
    @(negedge clk);
    check("b2b_idle1", 32'(busy), 32'd0);

    // Reset in WAIT_DATA drops outputs without a clock edge.
    rtiDecoded = 1'b1; memDataValid = 1'b0;
    @(negedge clk);
    rtiDecoded = 1'b0;
    repeat (D + 3) @(negedge clk);
    check("wait_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy",   32'(busy),        32'd0);
    check("arst_stall",  32'(stallFetch),  32'd0);
    check("arst_inject", 32'(injectValid), 32'd0);
    check("arst_pc",     restorePc,        32'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_pc = 32'h0; exp_fl = 3'h0;

    for (int k = 0; k < 6; k++) begin
      set_seq(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), int'($urandom_range(0, 9)),
              16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      run_seq(1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
